// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 set-2 scan code decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXT    = 2'd1,
    S_BRK    = 2'd2,
    S_EXTBRK = 2'd3
  } state_e;

endpackage

// File: rtl/ps2_ascii_lut.sv
// Set-2 scan code to ASCII: letters, digits (shifted to US symbols), space, enter.
module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic       w_is_letter;
  logic       w_is_digit;
  logic [7:0] w_idx;
  logic [7:0] w_dig_sym;

  always_comb begin
    w_is_letter = 1'b1;
    w_idx       = 8'd0;
    case (code)
      8'h1C: w_idx = 8'd0;   8'h32: w_idx = 8'd1;   8'h21: w_idx = 8'd2;
      8'h23: w_idx = 8'd3;   8'h24: w_idx = 8'd4;   8'h2B: w_idx = 8'd5;
      8'h34: w_idx = 8'd6;   8'h33: w_idx = 8'd7;   8'h43: w_idx = 8'd8;
      8'h3B: w_idx = 8'd9;   8'h42: w_idx = 8'd10;  8'h4B: w_idx = 8'd11;
      8'h3A: w_idx = 8'd12;  8'h31: w_idx = 8'd13;  8'h44: w_idx = 8'd14;
      8'h4D: w_idx = 8'd15;  8'h15: w_idx = 8'd16;  8'h2D: w_idx = 8'd17;
      8'h1B: w_idx = 8'd18;  8'h2C: w_idx = 8'd19;  8'h3C: w_idx = 8'd20;
      8'h2A: w_idx = 8'd21;  8'h1D: w_idx = 8'd22;  8'h22: w_idx = 8'd23;
      8'h35: w_idx = 8'd24;  8'h1A: w_idx = 8'd25;
      default: w_is_letter = 1'b0;
    endcase
  end

  always_comb begin
    w_is_digit = 1'b1;
    w_dig_sym  = 8'h00;
    case (code)
      8'h45: w_dig_sym = shift ? 8'h29 : 8'h30;
      8'h16: w_dig_sym = shift ? 8'h21 : 8'h31;
      8'h1E: w_dig_sym = shift ? 8'h40 : 8'h32;
      8'h26: w_dig_sym = shift ? 8'h23 : 8'h33;
      8'h25: w_dig_sym = shift ? 8'h24 : 8'h34;
      8'h2E: w_dig_sym = shift ? 8'h25 : 8'h35;
      8'h36: w_dig_sym = shift ? 8'h5E : 8'h36;
      8'h3D: w_dig_sym = shift ? 8'h26 : 8'h37;
      8'h3E: w_dig_sym = shift ? 8'h2A : 8'h38;
      8'h46: w_dig_sym = shift ? 8'h28 : 8'h39;
      default: w_is_digit = 1'b0;
    endcase
  end

  always_comb begin
    ascii = 8'h00;
    if (w_is_letter)        ascii = (shift ? 8'h41 : 8'h61) + w_idx;
    else if (w_is_digit)    ascii = w_dig_sym;
    else if (code == 8'h29) ascii = 8'h20;
    else if (code == 8'h5A) ascii = 8'h0D;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns the PS/2 receiver byte stream into make/break/repeat key events with ASCII and a press counter.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int COUNT_W     = 8,
  parameter bit SHIFT_UPPER = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         data,
  input  logic               flag,
  output logic               key_valid,
  output logic               key_break,
  output logic               key_repeat,
  output logic               key_down,
  output logic               key_ext,
  output logic [7:0]         key_code,
  output logic [7:0]         key_ascii,
  output logic [COUNT_W-1:0] press_count
);

  logic               r_flag_q;
  logic               w_new_byte;
  state_e             r_state, w_state_nxt;
  logic               w_evt_make, w_evt_brk, w_evt_ext;

  logic               r_key_valid, r_key_break, r_key_repeat, r_key_down, r_key_ext;
  logic [7:0]         r_key_code, r_key_ascii;
  logic [COUNT_W-1:0] r_press_count;
  logic               r_shift_l, r_shift_r;

  logic               w_valid_nxt, w_break_nxt, w_repeat_nxt, w_down_nxt, w_ext_nxt;
  logic [7:0]         w_code_nxt, w_lut_ascii;
  logic [COUNT_W-1:0] w_count_nxt;
  logic               w_shl_nxt, w_shr_nxt, w_lut_shift;
  logic               w_is_shl, w_is_shr, w_match;

  assign w_new_byte = flag ^ r_flag_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_flag_q <= 1'b0;
      r_state  <= S_IDLE;
    end else begin
      r_flag_q <= flag;
      r_state  <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_new_byte) begin
      if (data == SC_EXT)
        w_state_nxt = S_EXT;
      else if (data == SC_BRK)
        w_state_nxt = (r_state == S_EXT || r_state == S_EXTBRK) ? S_EXTBRK : S_BRK;
      else
        w_state_nxt = S_IDLE;
    end
  end

  // Any non-prefix byte completes an event; the state says which kind.
  always_comb begin
    w_evt_make = 1'b0;
    w_evt_brk  = 1'b0;
    w_evt_ext  = 1'b0;
    if (w_new_byte && data != SC_EXT && data != SC_BRK) begin
      w_evt_make = (r_state == S_IDLE) || (r_state == S_EXT);
      w_evt_brk  = (r_state == S_BRK)  || (r_state == S_EXTBRK);
      w_evt_ext  = (r_state == S_EXT)  || (r_state == S_EXTBRK);
    end
  end

  assign w_is_shl = (data == SC_LSHIFT) && !w_evt_ext;
  assign w_is_shr = (data == SC_RSHIFT) && !w_evt_ext;
  assign w_match  = (data == r_key_code) && (w_evt_ext == r_key_ext);

  always_comb begin
    w_valid_nxt  = 1'b0;
    w_break_nxt  = 1'b0;
    w_repeat_nxt = 1'b0;
    w_down_nxt   = r_key_down;
    w_ext_nxt    = r_key_ext;
    w_code_nxt   = r_key_code;
    w_count_nxt  = r_press_count;
    w_shl_nxt    = r_shift_l;
    w_shr_nxt    = r_shift_r;
    if (w_evt_make) begin
      if (w_is_shl)
        w_shl_nxt = 1'b1;
      else if (w_is_shr)
        w_shr_nxt = 1'b1;
      else if (r_key_down && w_match) begin
        w_valid_nxt  = 1'b1;
        w_repeat_nxt = 1'b1;
      end else begin
        w_valid_nxt = 1'b1;
        w_down_nxt  = 1'b1;
        w_code_nxt  = data;
        w_ext_nxt   = w_evt_ext;
        w_count_nxt = r_press_count + COUNT_W'(1);
      end
    end else if (w_evt_brk) begin
      if (w_is_shl)
        w_shl_nxt = 1'b0;
      else if (w_is_shr)
        w_shr_nxt = 1'b0;
      else begin
        w_break_nxt = 1'b1;
        if (w_match) w_down_nxt = 1'b0;
      end
    end
  end

  assign w_lut_shift = SHIFT_UPPER ? (w_shl_nxt | w_shr_nxt) : 1'b0;

  ps2_ascii_lut u_lut (
    .code  (w_code_nxt),
    .shift (w_lut_shift),
    .ascii (w_lut_ascii)
  );

  // ASCII is refreshed every cycle from the next code/shift, so it tracks both new keys and shift changes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_key_valid   <= 1'b0;
      r_key_break   <= 1'b0;
      r_key_repeat  <= 1'b0;
      r_key_down    <= 1'b0;
      r_key_ext     <= 1'b0;
      r_key_code    <= 8'h00;
      r_key_ascii   <= 8'h00;
      r_press_count <= '0;
      r_shift_l     <= 1'b0;
      r_shift_r     <= 1'b0;
    end else begin
      r_key_valid   <= w_valid_nxt;
      r_key_break   <= w_break_nxt;
      r_key_repeat  <= w_repeat_nxt;
      r_key_down    <= w_down_nxt;
      r_key_ext     <= w_ext_nxt;
      r_key_code    <= w_code_nxt;
      r_key_ascii   <= w_ext_nxt ? 8'h00 : w_lut_ascii;
      r_press_count <= w_count_nxt;
      r_shift_l     <= w_shl_nxt;
      r_shift_r     <= w_shr_nxt;
    end
  end

  assign key_valid   = r_key_valid;
  assign key_break   = r_key_break;
  assign key_repeat  = r_key_repeat;
  assign key_down    = r_key_down;
  assign key_ext     = r_key_ext;
  assign key_code    = r_key_code;
  assign key_ascii   = r_key_ascii;
  assign press_count = r_press_count;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a prefix-flag key model checked every cycle.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] data = 8'h00;
  logic       flag = 1'b0;
  logic       key_valid, key_break, key_repeat, key_down, key_ext;
  logic [7:0] key_code, key_ascii, press_count;

  int total = 0;
  int bad   = 0;

  ps2_scancode_decoder #(.COUNT_W(8), .SHIFT_UPPER(1'b1)) dut (
    .clk(clk), .resetn(resetn), .data(data), .flag(flag),
    .key_valid(key_valid), .key_break(key_break), .key_repeat(key_repeat),
    .key_down(key_down), .key_ext(key_ext), .key_code(key_code),
    .key_ascii(key_ascii), .press_count(press_count)
  );

  always #5 clk = ~clk;

  // Model: pending E0/F0 prefixes as two booleans, a held-key record and a shift pair.
  bit       m_flag_q = 0, m_pe = 0, m_pb = 0;
  bit       m_valid = 0, m_break = 0, m_repeat = 0, m_down = 0, m_ext = 0;
  bit       m_shl = 0, m_shr = 0;
  bit [7:0] m_code = 0, m_ascii = 0;
  int       m_count = 0;

  byte unsigned letter_sc[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                  8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                  8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  byte unsigned digit_sc[10]  = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  byte unsigned digit_up[10]  = '{")","!","@","#","$","%","^","&","*","("};

  function automatic bit [7:0] to_ascii(input bit [7:0] c, input bit e, input bit sh);
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (c == letter_sc[i]) return sh ? 8'(int'("A") + i) : 8'(int'("a") + i);
    for (int i = 0; i < 10; i++)
      if (c == digit_sc[i]) return sh ? digit_up[i] : 8'(int'("0") + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_byte(input bit [7:0] b);
    bit e;
    bit is_shift;
    if (b == 8'hE0) begin
      m_pe = 1; m_pb = 0;
    end else if (b == 8'hF0) begin
      m_pb = 1;
    end else begin
      e = m_pe;
      is_shift = !e && (b == 8'h12 || b == 8'h59);
      if (!m_pb) begin
        if (is_shift) begin
          if (b == 8'h12) m_shl = 1; else m_shr = 1;
        end else if (m_down && b == m_code && e == m_ext) begin
          m_valid = 1; m_repeat = 1;
        end else begin
          m_code = b; m_ext = e; m_down = 1; m_valid = 1;
          m_count = (m_count + 1) % 256;
        end
      end else begin
        if (is_shift) begin
          if (b == 8'h12) m_shl = 0; else m_shr = 0;
        end else begin
          m_break = 1;
          if (b == m_code && e == m_ext) m_down = 0;
        end
      end
      m_ascii = to_ascii(m_code, m_ext, m_shl | m_shr);
      m_pe = 0; m_pb = 0;
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_flag_q = 0; m_pe = 0; m_pb = 0;
      m_valid = 0; m_break = 0; m_repeat = 0; m_down = 0; m_ext = 0;
      m_shl = 0; m_shr = 0; m_code = 0; m_ascii = 0; m_count = 0;
    end else begin
      m_valid = 0; m_break = 0; m_repeat = 0;
      if (flag != m_flag_q) model_byte(data);
      m_flag_q = flag;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("key_valid",   32'(key_valid),   32'(m_valid));
    chk("key_break",   32'(key_break),   32'(m_break));
    chk("key_repeat",  32'(key_repeat),  32'(m_repeat));
    chk("key_down",    32'(key_down),    32'(m_down));
    chk("key_ext",     32'(key_ext),     32'(m_ext));
    chk("key_code",    32'(key_code),    32'(m_code));
    chk("key_ascii",   32'(key_ascii),   32'(m_ascii));
    chk("press_count", 32'(press_count), 32'(m_count));
  end

  // One byte, then wait until its result is visible.
  task automatic send(input bit [7:0] b);
    @(posedge clk); #1;
    data = b; flag = ~flag;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic burst(input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2, input bit [7:0] b3);
    bit [7:0] q[4];
    q = '{b0, b1, b2, b3};
    foreach (q[i]) begin
      @(posedge clk); #1;
      data = q[i]; flag = ~flag;
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 0; flag = 0; data = 8'h00;
    @(negedge clk);
    chk("rst_count", 32'(press_count), 32'd0);
    chk("rst_down",  32'(key_down),    32'd0);
    @(posedge clk); #1;
    resetn = 1;
  endtask

  initial begin
    // flag held high through reset: the first clock after release sees one byte (0x1C)
    resetn = 0; flag = 1; data = 8'h1C;
    repeat (2) @(negedge clk);
    chk("t1_reset_code",  32'(key_code),  32'd0);
    chk("t1_reset_valid", 32'(key_valid), 32'd0);
    @(posedge clk); #1; resetn = 1;
    @(posedge clk); @(negedge clk);
    chk("t2_valid", 32'(key_valid),   32'd1);
    chk("t2_code",  32'(key_code),    32'h1C);
    chk("t2_ascii", 32'(key_ascii),   32'h61);
    chk("t2_down",  32'(key_down),    32'd1);
    chk("t2_count", 32'(press_count), 32'd1);
    @(negedge clk);
    chk("t1_once", 32'(key_valid), 32'd0);

    send(8'h1C); chk("t3_rep1", 32'(key_repeat), 32'd1);
    send(8'h1C); chk("t3_rep2", 32'(key_repeat), 32'd1);
    chk("t3_count", 32'(press_count), 32'd1);
    send(8'hF0); chk("t3_prefix_quiet", 32'(key_break), 32'd0);
    send(8'h1C);
    chk("t3_break", 32'(key_break), 32'd1);
    chk("t3_down",  32'(key_down),  32'd0);
    chk("t3_hold_ascii", 32'(key_ascii), 32'h61);

    send(8'h12); chk("t4_shift_novalid", 32'(key_valid), 32'd0);
    send(8'h1C);
    chk("t4_upper", 32'(key_ascii),   32'h41);
    chk("t4_count", 32'(press_count), 32'd2);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    chk("t4_shift_cleared", 32'(key_ascii), 32'h61);
    send(8'h1C);
    chk("t4_lower", 32'(key_ascii),   32'h61);
    chk("t4_count3", 32'(press_count), 32'd3);
    send(8'h59);
    send(8'h16); chk("rshift_bang", 32'(key_ascii), 32'h21);
    send(8'hF0); send(8'h59); chk("rshift_one", 32'(key_ascii), 32'h31);
    send(8'hF0); send(8'h16);

    send(8'hE0); send(8'h75);
    chk("t5_ext",   32'(key_ext),     32'd1);
    chk("t5_ascii", 32'(key_ascii),   32'd0);
    chk("t5_count", 32'(press_count), 32'd5);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t5_break", 32'(key_break), 32'd1);
    chk("t5_down",  32'(key_down),  32'd0);

    burst(8'h32, 8'h32, 8'hF0, 8'h32);
    chk("burst_count", 32'(press_count), 32'd6);
    chk("burst_ascii", 32'(key_ascii),   32'h62);
    chk("burst_down",  32'(key_down),    32'd0);

    do_reset();
    for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
    chk("t6_wrap", 32'(press_count), 32'd0);
    chk("t6_code", 32'(key_code),    32'h32);

    send(8'hF0);
    do_reset();
    send(8'h1C);
    chk("t6_rst_make",  32'(key_valid),   32'd1);
    chk("t6_rst_break", 32'(key_break),   32'd0);
    chk("t6_rst_count", 32'(press_count), 32'd1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
